// File: rtl/display_mux_controller_pkg.sv
// Shared types and anode encodings for the two-digit display multiplexer.
package display_pkg;

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } disp_state_t;

    localparam logic [1:0] AN_OFF = 2'b11;
    localparam logic [1:0] AN_D0  = 2'b10;
    localparam logic [1:0] AN_D1  = 2'b01;

    function automatic logic [1:0] an_for(input disp_state_t s);
        case (s)
            SHOW0:   an_for = AN_D0;
            SHOW1:   an_for = AN_D1;
            default: an_for = AN_OFF;
        endcase
    endfunction

    // The select leads into BLANK0 so it is settled before digit 1 lights.
    function automatic logic hex_for(input disp_state_t s);
        hex_for = (s == BLANK0) || (s == SHOW1);
    endfunction

endpackage

// File: rtl/display_mux_controller_slot_timer.sv
// Down-counting slot timer: load a length, count down while enabled, done on the last cycle.
module slot_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == W'(1));

endmodule

// File: rtl/display_mux_controller.sv
// Dual 7-segment sequencer: digit select, per-frame operand latch and blanked anode drive.
module display_mux_controller
    import display_pkg::*;
#(
    parameter int DIV_COUNT   = 24000,
    parameter int BLANK_COUNT = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s1_in,
    input  logic [3:0] s2_in,
    output logic       current_hex,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [1:0] an,
    output logic       frame_tick
);

    // state  | meaning
    // SHOW0  | digit 0 lit, select 0
    // BLANK0 | dark gap, select pre-set to 1
    // SHOW1  | digit 1 lit, select 1
    // BLANK1 | dark gap, select back to 0; reset state

    localparam int MAX_LEN = (DIV_COUNT > BLANK_COUNT) ? DIV_COUNT : BLANK_COUNT;
    localparam int CW      = $clog2(((MAX_LEN > 1) ? MAX_LEN : 1) + 1);
    localparam logic [CW-1:0] SHOW_LEN   = CW'(DIV_COUNT);
    localparam logic [CW-1:0] BLANK_LEN  = CW'(BLANK_COUNT);
    localparam logic [CW-1:0] RESUME_LEN = CW'((BLANK_COUNT > 1) ? BLANK_COUNT - 1 : 0);
    localparam bit            NO_BLANK   = (BLANK_COUNT == 0);

    disp_state_t state_q, state_d;
    logic [1:0]  an_q, an_d;
    logic        hex_q, hex_d;
    logic        tick_q, tick_d;
    logic [3:0]  s1_q, s1_d, s2_q, s2_d;

    logic [CW-1:0] tmr_count, tmr_val;
    logic          tmr_done, tmr_load;
    logic          leave, unarmed, frame_start;

    slot_timer #(.W(CW)) u_slot_timer (
        .clk      (clk),
        .rst      (reset),
        .en       (en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // A zero count only exists straight after reset: the first enabled cycle
    // of BLANK1 either ends it (short blank) or arms the rest of its length.
    always_comb begin
        leave   = tmr_done || ((tmr_count == '0) && (BLANK_COUNT <= 1));
        unarmed = (tmr_count == '0) && !leave;
        state_d = state_q;
        if (en && leave) begin
            case (state_q)
                SHOW0:   state_d = NO_BLANK ? SHOW1 : BLANK0;
                BLANK0:  state_d = SHOW1;
                SHOW1:   state_d = NO_BLANK ? SHOW0 : BLANK1;
                default: state_d = SHOW0;
            endcase
        end
        tmr_load    = en && (leave || unarmed);
        tmr_val     = unarmed ? RESUME_LEN :
                      ((state_d == SHOW0) || (state_d == SHOW1)) ? SHOW_LEN : BLANK_LEN;
        frame_start = en && leave && (state_d == SHOW0);
        an_d        = en ? an_for(state_d) : AN_OFF;
        hex_d       = hex_for(state_d);
        tick_d      = frame_start;
        s1_d        = frame_start ? s1_in : s1_q;
        s2_d        = frame_start ? s2_in : s2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK1;
            an_q    <= AN_OFF;
            hex_q   <= 1'b0;
            tick_q  <= 1'b0;
            s1_q    <= 4'h0;
            s2_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            an_q    <= an_d;
            hex_q   <= hex_d;
            tick_q  <= tick_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    assign an          = an_q;
    assign current_hex = hex_q;
    assign frame_tick  = tick_q;
    assign s1          = s1_q;
    assign s2          = s2_q;

endmodule

// File: doc/display_mux_controller.md
# display_mux_controller

Sequencer for the time-multiplexed dual 7-segment display. It drives the `segment_decoder` select (`current_hex`) and its two hex operands, and generates the active-low anode enables for the two digits. It inserts a programmable blanking gap between digits to suppress ghosting. Operands are captured once per frame so a digit never changes while it is lit.

## Interface
- `DIV_COUNT`, default 24000: cycles each digit is lit per frame (≥1).
- `BLANK_COUNT`, default 240: cycles both anodes are off between digits (≥0).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable; when low, the sequence freezes and the display is dark.
- `s1_in`  in  4  hex value for digit 0.
- `s2_in`  in  4  hex value for digit 1.
- `current_hex`  out  1  decoder select: 0 selects `s1`, 1 selects `s2`.
- `s1`  out  4  latched digit-0 operand to the decoder.
- `s2`  out  4  latched digit-1 operand to the decoder.
- `an`  out  2  anode enables, active-low; `an[0]` is digit 0, `an[1]` is digit 1.
- `frame_tick`  out  1  one-cycle pulse when a new frame starts and the operands are latched.

## Operation
- FSM states: SHOW0, BLANK0, SHOW1, BLANK1. All outputs are registered or decoded from registered state only.
- Per-state outputs:
  - SHOW0: `an`=2'b10, `current_hex`=0.
  - BLANK0: `an`=2'b11, `current_hex`=1. The select pre-settles for the next digit.
  - SHOW1: `an`=2'b01, `current_hex`=1.
  - BLANK1: `an`=2'b11, `current_hex`=0.
- Slot counter: loads on state entry and advances one per enabled cycle.
  - SHOW states last DIV_COUNT cycles.
  - BLANK states last BLANK_COUNT cycles.
  - If BLANK_COUNT=0, both BLANK states are skipped: SHOW0→SHOW1→SHOW0.
- Transition order: SHOW0→BLANK0→SHOW1→BLANK1→SHOW0.
- On entry to SHOW0 (the frame boundary):
  - `s1`←`s1_in` and `s2`←`s2_in`.
  - `frame_tick` is 1 for that single cycle.
  - The value present at that clock edge is the one captured; changes at any other time are ignored until the next boundary.
- `en`=0:
  - State, counter and latches hold.
  - `an` is forced to 2'b11 and `frame_tick` to 0; `current_hex` holds.
  - On `en`=1 the sequence resumes with the remaining slot count.
- Counter width: $clog2(max(DIV_COUNT, BLANK_COUNT, 1)+1). There is no overflow path, because the counter reloads on every state exit.

## Timing
- Reset values (asynchronous, immediate):
  - State is BLANK1 with the counter cleared.
  - `an`=2'b11, `current_hex`=0, `s1`=0, `s2`=0, `frame_tick`=0.
- Reset exit:
  - BLANK1 lasts max(BLANK_COUNT, 1) enabled cycles.
  - Then SHOW0 is entered with the first latch and the first `frame_tick`.
- Frame period: 2×(DIV_COUNT+BLANK_COUNT) enabled cycles. `frame_tick` recurs at exactly that spacing.
- Anode-to-select ordering:
  - `current_hex` never changes on the same edge an anode turns on.
  - Exception: with BLANK_COUNT=0, `an` and `current_hex` change together on one edge.
- Reset mid-frame: all outputs return to reset values asynchronously. Behaviour after release is identical to power-up.
- `en` deasserted on the cycle a transition would occur: the transition does not happen and completes on the first re-enabled cycle.

## Structure
- Package `display_pkg`:
  - State enum typedef `disp_state_t`.
  - Anode constants `AN_OFF`=2'b11, `AN_D0`=2'b10, `AN_D1`=2'b01.
- Sub-module `slot_timer`:
  - Parameterised width.
  - Loads a count and decrements while enabled.
  - Asserts `done` on the last cycle.
  - The FSM instantiates one of them.
- The top level instantiates `display_mux_controller` feeding `segment_decoder` directly.

## Test plan
All scenarios use DIV_COUNT=4 and BLANK_COUNT=2 unless noted; the frame is 12 cycles.
- Reset release with `s1_in`=4'h4 and `s2_in`=4'hD:
  - `an`=11 for 2 cycles, then `frame_tick` pulses and `s1`=4, `s2`=D.
  - Then `an`=10 for 4 cycles, 11 for 2, 01 for 4, 11 for 2, repeating.
- Free run for 5 frames: `frame_tick` spacing is exactly 12 cycles. `current_hex` toggles on the SHOW0→BLANK0 and SHOW1→BLANK1 edges only.
- Change `s2_in` from 5 to C mid-SHOW1: `s2` stays 5 until the next `frame_tick` edge, then becomes C.
- `en` low for 7 cycles during cycle 2 of SHOW0:
  - `an`=11 throughout and `frame_tick` never pulses.
  - After re-enable, SHOW0 lasts the remaining 2 cycles.
- With BLANK_COUNT=0: `an` alternates 10 and 01 every 4 cycles, never 11 after the first frame, and the frame is 8 cycles.
- `reset` asserted between clock edges during SHOW1: `an`=11, `s1`=`s2`=0 and `current_hex`=0 immediately. Power-up sequencing repeats after release.
